// File: rtl/card_game_pkg.sv
// Shared types for the memory card game: card mask/address types and the
// select-controller state encoding.
package card_game_pkg;

  localparam int NUM_CARDS = 36;
  localparam int ADDR_W    = 6;

  typedef logic [NUM_CARDS-1:0] card_mask_t;
  typedef logic [ADDR_W-1:0]    card_addr_t;

  typedef enum logic [2:0] {
    PICK1,
    PICK2,
    WAIT_CMP,
    HOLD,
    DONE
  } sel_state_t;

  // One-hot mask with only the bit of the given card set.
  function automatic card_mask_t card_bit(input card_addr_t addr);
    return card_mask_t'(1) << addr;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// N-bit rising-edge detector for already-synchronised button levels.
// The previous level is registered; rise is high for the first cycle of a press.
module btn_edge #(
  parameter int N = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] level,
  output logic [N-1:0] rise
);

  logic [N-1:0] prev;

  // NOTE: sequential state is written with non-blocking (<=) assignments only,
  // so every register samples the values from before the clock edge.
  always_ff @(posedge clock) begin
    if (reset) prev <= '0;
    else       prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/card_select_ctrl.sv
// Player-input front end of the memory card game: cursor movement, card
// selection strobes, pick state and the face-up mask shown by the renderer.
module card_select_ctrl
  import card_game_pkg::*;
#(
  parameter int GRID_W      = 6,
  parameter int GRID_H      = 6,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_a,
  input  logic             match_valid,
  input  logic             match_hit,
  input  logic             game_over,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic             sel_pulse,
  output logic             pick_state,
  output logic [NUM_CARDS-1:0] face_up,
  output logic             busy
);

  // Counter holds HOLD_CYCLES-1 down to 0, so it needs clog2(HOLD_CYCLES) bits.
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam card_addr_t LAST_ROW = card_addr_t'(GRID_H - 1);
  localparam card_addr_t LAST_COL = card_addr_t'(GRID_W - 1);
  localparam card_addr_t ADDR_ONE = card_addr_t'(1);

  logic [4:0] rise;
  logic       up_e, down_e, left_e, right_e, a_e;

  btn_edge #(.N(5)) u_btn_edge (
    .clock (clock),
    .reset (reset),
    .level ({btn_up, btn_down, btn_left, btn_right, btn_a}),
    .rise  (rise)
  );

  assign {up_e, down_e, left_e, right_e, a_e} = rise;

  sel_state_t       state;
  card_addr_t       row, col;
  card_addr_t       first_addr, second_addr;
  card_mask_t       matched;
  logic [CNT_W-1:0] hold_cnt;
  logic             move_ok, a_free;

  assign cursor_addr = card_addr_t'(row * card_addr_t'(GRID_W) + col);
  assign move_ok     = (state == PICK1) || (state == PICK2) || (state == HOLD);
  assign a_free      = a_e && !matched[cursor_addr];

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= PICK1;
      row         <= '0;
      col         <= '0;
      first_addr  <= '0;
      second_addr <= '0;
      matched     <= '0;
      hold_cnt    <= '0;
      sel_pulse   <= 1'b0;
      pick_state  <= 1'b0;
      busy        <= 1'b0;
    end else if (game_over || state == DONE) begin
      // Frozen until reset; only the strobe is dropped.
      state     <= DONE;
      sel_pulse <= 1'b0;
    end else begin
      sel_pulse <= 1'b0;

      if (move_ok) begin
        if (up_e)         row <= (row == '0)       ? LAST_ROW : row - ADDR_ONE;
        else if (down_e)  row <= (row == LAST_ROW) ? '0       : row + ADDR_ONE;
        else if (left_e)  col <= (col == '0)       ? LAST_COL : col - ADDR_ONE;
        else if (right_e) col <= (col == LAST_COL) ? '0       : col + ADDR_ONE;
      end

      case (state)
        PICK1: begin
          if (a_free) begin
            first_addr <= cursor_addr;
            sel_pulse  <= 1'b1;
            state      <= PICK2;
          end
        end
        PICK2: begin
          // pick_state rises one cycle late so the comparator sees the old
          // value alongside the first select strobe.
          if (sel_pulse) pick_state <= 1'b1;
          if (a_free && cursor_addr != first_addr) begin
            second_addr <= cursor_addr;
            sel_pulse   <= 1'b1;
            busy        <= 1'b1;
            state       <= WAIT_CMP;
          end
        end
        WAIT_CMP: begin
          if (match_valid) begin
            if (match_hit) begin
              matched    <= matched | card_bit(first_addr) | card_bit(second_addr);
              pick_state <= 1'b0;
              busy       <= 1'b0;
              state      <= PICK1;
            end else begin
              hold_cnt <= HOLD_LOAD;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            first_addr  <= '0;
            second_addr <= '0;
            pick_state  <= 1'b0;
            busy        <= 1'b0;
            state       <= PICK1;
          end else begin
            hold_cnt <= hold_cnt - CNT_W'(1);
          end
        end
        default: state <= PICK1;
      endcase
    end
  end

  // NOTE: face_up gets a full default before any conditional update, so no
  // path through this block leaves it unassigned and no latch is inferred.
  always_comb begin
    face_up = matched;
    if (state == PICK2 || state == WAIT_CMP || state == HOLD)
      face_up = face_up | card_bit(first_addr);
    if (state == WAIT_CMP || state == HOLD)
      face_up = face_up | card_bit(second_addr);
    if (state == DONE)
      face_up = '1;
  end

endmodule
